data_out_write_arbiter: RTL and testbench
=========================================

// Module: data_out_write_arbiter
// PURPOSE
//  Shares one DATA_W-bit output register between NUM_REQ requesters: round-robin arbitration, then a data write or a clear-to-zero.
//  Sits in front of the register-write tasks and sequences every access to data_out, so writers never collide.
//  Also keeps a wrapping count of completed writes for debug and coverage.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  DATA_W   8   width of data_out and of each requester's data
//  CNT_W    16  width of wr_count
// PORTS
//  clk        in   1               single clock, rising edge
//  rst_n      in   1               asynchronous active-low reset
//  req        in   NUM_REQ         per-requester write request, level, held until ack
//  clr        in   NUM_REQ         per-requester: 1 = write zeros instead of wdata (sampled with req)
//  wdata      in   NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
//  soft_clr   in   1               synchronous global clear/abort
//  grant      out  NUM_REQ         one-hot owner of the in-flight access, 0 when idle
//  ack        out  NUM_REQ         one-cycle pulse to the requester whose write completed
//  busy       out  1               state != IDLE
//  data_out   out  DATA_W          the shared register
//  wr_count   out  CNT_W           completed writes modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, grant=0, ack=0, busy=0, data_out=0, wr_count=0, rr_ptr=0.
//  FSM: IDLE -> GRANT -> WRITE -> IDLE.
//   IDLE : if |req, pick the first set req[i] searching from rr_ptr upward with wrap; register grant[i]; go to GRANT.
//   GRANT: grant held.
//          if req[i] still 1: latch sel_data = clr[i] ? 0 : wdata[i]; go to WRITE.
//          else: abort, no write, no ack, rr_ptr unchanged, go to IDLE.
//   WRITE: data_out <= sel_data; ack[i] pulses this cycle; wr_count += 1 (wraps);
//          rr_ptr <= (i+1) mod NUM_REQ; grant <= 0; go to IDLE.
//  Latency: req rises at edge 0 in IDLE -> grant visible after edge 1 -> data_out/ack after edge 3.
//   Back-to-back accesses every 3 cycles.
//  ack and grant are one-hot or zero; at most one ack per 3 cycles.
//  Requesters must drop req the cycle after ack. A req still high in IDLE is treated as a new request.
//  clr and wdata are sampled only in GRANT; changes at other times are ignored.
//  soft_clr=1 (any state, highest priority): next edge data_out=0, state=IDLE, grant=0, no ack.
//   wr_count and rr_ptr unchanged. Arbitration is suppressed while soft_clr is held.
//  soft_clr in WRITE cancels that write: data_out ends 0, no ack, no count.
//  rr_ptr only advances on completed writes; aborted or cancelled grants do not rotate priority.
//  wr_count wraps 2^CNT_W-1 -> 0 with no flag.
//  rst_n asserted mid-access: immediate return to reset values; the in-flight write is lost and its ack never issued.
// TESTING
//  T1 reset: rst_n=0 mid-WRITE with data_out=0x5A -> immediately data_out=0, grant=0, busy=0, wr_count=0.
//  T2 single write: req[2]=1, wdata[2]=0xA5, clr=0 ->
//     grant=4'b0100 after 1 edge; data_out=0xA5 and ack[2] pulse after 3 edges; wr_count=1.
//  T3 round robin: req=4'b1111 held, each requester dropping req after its own ack ->
//     grant order 0,1,2,3, acks 3 cycles apart.
//  T4 clear + abort: req[1] with clr[1]=1, data_out=0x3C -> data_out=0x00, ack[1].
//     Separately, req[3] dropped during GRANT -> no ack, data_out and rr_ptr unchanged.
//  T5 soft_clr: assert soft_clr in WRITE for req[0] (wdata=0xFF) ->
//     data_out=0, no ack[0], wr_count unchanged, FSM IDLE.
//  T6 counter wrap: CNT_W=4, 16 completed writes -> wr_count 15 -> 0.
//     A random req/clr/soft_clr run checks grant one-hot and data_out matches the reference model.

Source files
------------

// File: rtl/data_out_write_arbiter.sv
// rtl/data_out_write_arbiter.sv - round-robin arbiter sequencing writes/clears into a shared data_out register
// Three-state access: IDLE picks a requester, GRANT samples its data, WRITE commits and acks.
module data_out_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          clr,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  input  logic                        soft_clr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [DATA_W-1:0]           data_out,
  output logic [CNT_W-1:0]            wr_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_ack;
  logic [PTR_W-1:0]    r_gidx;
  logic [PTR_W-1:0]    r_ptr;
  logic [DATA_W-1:0]   r_sel_data;
  logic [DATA_W-1:0]   r_data_out;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_load_grant;
  logic                w_latch;
  logic                w_abort;
  logic                w_commit;
  logic [PTR_W-1:0]    w_pick;
  logic [PTR_W-1:0]    w_ptr_next;

  // First asserted request at or above the priority pointer, wrapping around.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [PTR_W-1:0]   p);
    logic [PTR_W-1:0] sel;
    logic             found;
    int               c;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(p) + k) % NUM_REQ;
      if (!found && r[PTR_W'(c)]) begin
        found = 1'b1;
        sel   = PTR_W'(c);
      end
    end
    return sel;
  endfunction

  assign w_pick     = rr_pick(req, r_ptr);
  assign w_ptr_next = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_grant = 1'b0;
    w_latch      = 1'b0;
    w_abort      = 1'b0;
    w_commit     = 1'b0;
    if (soft_clr) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            w_load_grant = 1'b1;
            w_next_state = GRANT;
          end
        end
        GRANT: begin
          if (req[r_gidx]) begin
            w_latch      = 1'b1;
            w_next_state = WRITE;
          end else begin
            w_abort      = 1'b1;
            w_next_state = IDLE;
          end
        end
        WRITE: begin
          w_commit     = 1'b1;
          w_next_state = IDLE;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= '0;
      r_ack      <= '0;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_sel_data <= '0;
      r_data_out <= '0;
      r_cnt      <= '0;
    end else begin
      r_ack <= '0;
      if (soft_clr) begin
        // Cancels any in-flight access; counter and priority are left alone.
        r_grant    <= '0;
        r_data_out <= '0;
      end else begin
        if (w_load_grant) begin
          r_grant <= NUM_REQ'(1) << w_pick;
          r_gidx  <= w_pick;
        end
        if (w_latch) begin
          r_sel_data <= clr[r_gidx] ? '0 : wdata[r_gidx*DATA_W +: DATA_W];
        end
        if (w_abort) begin
          r_grant <= '0;
        end
        if (w_commit) begin
          r_data_out <= r_sel_data;
          r_ack      <= r_grant;
          r_cnt      <= r_cnt + 1'b1;
          r_ptr      <= w_ptr_next;
          r_grant    <= '0;
        end
      end
    end
  end

  assign grant    = r_grant;
  assign ack      = r_ack;
  assign busy     = (r_state != IDLE);
  assign data_out = r_data_out;
  assign wr_count = r_cnt;

endmodule

// File: tb/tb_data_out_write_arbiter.sv
// tb/tb_data_out_write_arbiter.sv - scoreboard bench for data_out_write_arbiter
// A cycle reference model pushes each completed write; the monitor pops on every DUT ack.
module tb_data_out_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR-1:0]     clr;
  logic [NR*DW-1:0]  wdata;
  logic              soft_clr;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     ack;
  logic              busy;
  logic [DW-1:0]     data_out;
  logic [CW-1:0]     wr_count;

  data_out_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .clr      (clr),
    .wdata    (wdata),
    .soft_clr (soft_clr),
    .grant    (grant),
    .ack      (ack),
    .busy     (busy),
    .data_out (data_out),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model
  typedef enum logic [1:0] {M_IDLE, M_GRANT, M_WRITE} m_state_t;
  typedef struct { int idx; logic [DW-1:0] data; } exp_t;

  m_state_t      m_state;
  logic [NR-1:0] m_grant, m_ack;
  int            m_idx, m_ptr;
  logic [DW-1:0] m_sel, m_dout;
  logic [CW-1:0] m_cnt;
  exp_t          exp_q[$];

  function automatic int first_from(input logic [NR-1:0] r, input int p);
    logic [2*NR-1:0] d;
    d = {r, r} >> p;
    for (int k = 0; k < NR; k++) if (d[k]) return (p + k) % NR;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= M_IDLE; m_grant <= '0; m_ack <= '0; m_idx <= 0; m_ptr <= 0;
      m_sel <= '0; m_dout <= '0; m_cnt <= '0;
    end else begin
      m_ack <= '0;
      if (soft_clr) begin
        m_state <= M_IDLE; m_grant <= '0; m_dout <= '0;
      end else begin
        case (m_state)
          M_IDLE: if (req != 0) begin
            m_idx   <= first_from(req, m_ptr);
            m_grant <= NR'(1) << first_from(req, m_ptr);
            m_state <= M_GRANT;
          end
          M_GRANT: if (req[m_idx]) begin
            m_sel   <= clr[m_idx] ? '0 : wdata[m_idx*DW +: DW];
            m_state <= M_WRITE;
          end else begin
            m_grant <= '0;
            m_state <= M_IDLE;
          end
          default: begin
            m_dout  <= m_sel;
            m_ack   <= NR'(1) << m_idx;
            m_cnt   <= m_cnt + 1'b1;
            m_ptr   <= (m_idx + 1) % NR;
            m_grant <= '0;
            m_state <= M_IDLE;
            exp_q.push_back('{m_idx, m_sel});
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      exp_t e;
      check("mon_grant", grant, m_grant);
      check("mon_ack", ack, m_ack);
      check("mon_data_out", data_out, m_dout);
      check("mon_busy", busy, m_state != M_IDLE);
      check("mon_wr_count", wr_count, m_cnt);
      check("mon_onehot", $onehot0(grant) && $onehot0(ack), 1);
      if (ack != 0) begin
        if (exp_q.size() == 0) check("sb_unexpected_ack", ack, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_ack", ack, 1 << e.idx);
          check("sb_data", data_out, e.data);
        end
      end
    end
  end

  task automatic reset_dut();
    tick();
    rst_n = 1'b0; req = '0; clr = '0; soft_clr = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_write(input int idx, input logic [DW-1:0] d, input logic c, output int lat);
    int n;
    req[idx] = 1'b1; clr[idx] = c; wdata[idx*DW +: DW] = d;
    n = 0;
    do begin tick(); n++; end while (!ack[idx] && n < 12);
    check("ack_timeout", ack[idx], 1);
    req[idx] = 1'b0; clr[idx] = 1'b0;
    lat = n;
  endtask

  int lat, k, last_cyc, cyc, who;

  initial begin
    rst_n = 1'b0; req = '0; clr = '0; wdata = '0; soft_clr = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    check("rst_wr_count", wr_count, 0);
    tick(); tick();
    rst_n = 1'b1; mon_en = 1'b1;

    // single write with latency
    req[2] = 1'b1; wdata[2*DW +: DW] = 8'hA5;
    tick();
    check("t2_grant", grant, 4'b0100);
    tick();
    check("t2_busy", busy, 1);
    tick();
    check("t2_ack", ack, 4'b0100);
    check("t2_data", data_out, 8'hA5);
    check("t2_count", wr_count, 1);
    req[2] = 1'b0;
    tick();
    check("t2_ack_pulse", ack, 0);

    // async reset in the middle of a write
    do_write(1, 8'h5A, 1'b0, lat);
    check("t1_lat", lat, 3);
    check("t1_pre_data", data_out, 8'h5A);
    req[2] = 1'b1; wdata[2*DW +: DW] = 8'h11;
    tick(); tick();
    check("t1_in_write", busy, 1);
    rst_n = 1'b0; req = '0;
    #1;
    check("t1_data", data_out, 0);
    check("t1_grant", grant, 0);
    check("t1_busy", busy, 0);
    check("t1_count", wr_count, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;

    // round robin with all requesters
    reset_dut();
    for (int i = 0; i < NR; i++) wdata[i*DW +: DW] = DW'(8'h10 + i);
    req = 4'b1111; k = 0; cyc = 0; last_cyc = 0;
    while (k < NR && cyc < 40) begin
      tick(); cyc++;
      if (ack != 0) begin
        who = first_from(ack, 0);
        check("t3_order", who, k);
        check("t3_data", data_out, 8'h10 + k);
        if (k > 0) check("t3_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        req[who] = 1'b0;
        k++;
      end
    end
    check("t3_all_acked", k, NR);

    // clear write, then abort in GRANT
    do_write(0, 8'h3C, 1'b0, lat);
    check("t4_pre_data", data_out, 8'h3C);
    do_write(1, 8'h77, 1'b1, lat);
    check("t4_clr_data", data_out, 0);
    check("t4_clr_ack", ack, 4'b0010);
    check("t4_count", wr_count, 6);
    req[3] = 1'b1; wdata[3*DW +: DW] = 8'hEE;
    tick();
    check("t4_abort_grant", grant, 4'b1000);
    req[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_abort_noack", ack, 0);
    end
    check("t4_abort_data", data_out, 0);
    check("t4_abort_count", wr_count, 6);
    req = 4'b1010;
    tick();
    check("t4_ptr_kept", grant, 4'b1000);
    req = '0;
    tick(); tick();

    // soft clear cancels a write in progress
    req[0] = 1'b1; wdata[0 +: DW] = 8'hFF;
    tick();
    check("t5_grant", grant, 4'b0001);
    tick();
    check("t5_busy", busy, 1);
    soft_clr = 1'b1;
    tick();
    check("t5_data", data_out, 0);
    check("t5_noack", ack, 0);
    check("t5_idle", busy, 0);
    check("t5_grant_off", grant, 0);
    check("t5_count", wr_count, 6);
    soft_clr = 1'b0; req = '0;
    tick(); tick(); tick();
    check("t5_still_noack", wr_count, 6);

    // counter wrap with a 4-bit counter
    reset_dut();
    for (int i = 0; i < 15; i++) do_write(i % NR, DW'(i + 1), 1'b0, lat);
    check("t6_count15", wr_count, 15);
    do_write(2, 8'h99, 1'b0, lat);
    check("t6_wrap", wr_count, 0);
    check("t6_data", data_out, 8'h99);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      req      = NR'($urandom);
      clr      = NR'($urandom);
      wdata    = $urandom;
      soft_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    req = '0; soft_clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
